sar_max_search: RTL

SAR_MAX_SEARCH -- requirements
Module: sar_max_search

---
 rtl/sar_max_search.sv | 113 +++++++++++
 1 files changed

// File: rtl/sar_max_search.sv
// sar_max_search
//   Successive-approximation search for a hidden value y using only an
//   external "y > probe" comparator. One bit is decided per accepted
//   comparator answer, MSB first, so a search takes exactly WIDTH answers.
//
//   state | meaning
//   IDLE  | waiting for start; probe and probe_valid held at 0
//   PROBE | probe presented, waiting for gt_valid to decide bit idx
//   DONE  | one-cycle done pulse; result already holds the recovered y
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   start        begin a new search (IDLE only)
//   abort        cancel the search in progress / suppress start
//   probe        trial value presented to the comparator
//   probe_valid  probe is stable and awaiting an answer
//   gt           comparator answer: y > probe
//   gt_valid     gt is valid this cycle
//   busy         high in PROBE and DONE
//   done         one-cycle pulse when result becomes valid
//   result       recovered y; held until the next accepted start
module sar_max_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             gt,
  input  logic             gt_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cand;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] mask;
  logic             launch;
  logic             accept;

  // cand only has bits above idx set, so adding 2^idx-1 never carries out.
  assign mask   = (WIDTH'(1) << idx) - WIDTH'(1);
  assign launch = (state == IDLE) && start && !abort;
  assign accept = (state == PROBE) && gt_valid && !abort;

  always_comb begin
    state_nxt   = state;
    probe       = '0;
    probe_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_nxt = PROBE;
      end
      PROBE: begin
        probe       = cand + mask;
        probe_valid = 1'b1;
        busy        = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (accept && (idx == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cand   <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        cand   <= '0;
        idx    <= IW'(WIDTH - 1);
        result <= '0;
      end else if (accept) begin
        cand[idx] <= gt;
        if (idx != '0) begin
          idx <= idx - IW'(1);
        end else begin
          // bit 0 is being decided right now, so splice it in directly
          result <= {cand[WIDTH-1:1], gt};
        end
      end
    end
  end

endmodule
